uart_cmd_parser: RTL and testbench

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_cmd_pkg.sv | 20 ++
 rtl/uart_cmd_timeout.sv | 35 +++
 rtl/uart_cmd_parser.sv | 192 +++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared constants and state type for the UART command parser
//
// Contents:
//   SOF       - start-of-frame marker byte
//   BUF_DEPTH - payload buffer depth (bytes)
//   state_t   - parser state enumeration
package uart_cmd_pkg;

    localparam logic [7:0] SOF       = 8'hA5;
    localparam int         BUF_DEPTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/uart_cmd_timeout.sv
// rtl/uart_cmd_timeout.sv - inter-byte timeout counter for the UART command parser
//
// Ports:
//   i_clk, i_reset_n - clock, asynchronous active-low reset
//   i_reload         - an accepted byte restarts the count
//   i_enable         - count only while a frame is in progress; idle clears it
//   o_expire         - combinational, high in the cycle the count reaches TIMEOUT_CLK-1
module uart_cmd_timeout #(
    parameter int TIMEOUT_CLK = 26040
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_reload,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CW = $clog2(TIMEOUT_CLK + 1);

    logic [CW-1:0] cnt;

    // A reload in the same cycle suppresses expiry: the byte wins.
    assign o_expire = i_enable && !i_reload && (cnt == CW'(TIMEOUT_CLK - 1));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt <= '0;
        end else if (i_reload || o_expire || !i_enable) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - framed command parser behind a UART byte receiver
//
// Frame: SOF(0xA5), LEN, LEN payload bytes, CHK = XOR(LEN, payload).
// Optional feature macro: UART_CMD_STATS_EN enables the good/error counters.
//
// Ports:
//   i_clk, i_reset_n        - clock, asynchronous active-low reset
//   i_rx_valid, i_rx_byte   - receiver byte level strobe and data (rising edge accepted)
//   i_frame_ack             - releases a held frame
//   i_rd_addr, o_rd_data    - combinational payload read port (0 beyond frame length)
//   o_frame_valid           - a checked frame is held
//   o_frame_len             - payload length of the held frame
//   o_busy                  - frame reception in progress
//   o_err_chk/len/timeout   - registered single-cycle error pulses
//   o_overrun               - byte arrived while a frame was held
//   o_good_cnt, o_err_cnt   - saturating statistics (zero without UART_CMD_STATS_EN)
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int MAX_LEN     = 16,
    parameter int TIMEOUT_CLK = 26040
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_byte,
    input  logic        i_frame_ack,
    input  logic [3:0]  i_rd_addr,
    output logic [7:0]  o_rd_data,
    output logic        o_frame_valid,
    output logic [4:0]  o_frame_len,
    output logic        o_busy,
    output logic        o_err_chk,
    output logic        o_err_len,
    output logic        o_err_timeout,
    output logic        o_overrun,
    output logic [15:0] o_good_cnt,
    output logic [15:0] o_err_cnt
);

    state_t      state, state_nx;
    logic        rx_prev;
    logic        accept;
    logic        expire;
    logic        store;
    logic        err_chk_d, err_len_d, overrun_d;
    logic [4:0]  len_q;
    logic [4:0]  idx_q;
    logic [7:0]  chk_q;
    logic [7:0]  buf_mem [BUF_DEPTH];

    // The receiver holds valid as a level; only its first cycle is a byte.
    assign accept = i_rx_valid && !rx_prev;
    assign o_busy = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHK);

    uart_cmd_timeout #(
        .TIMEOUT_CLK (TIMEOUT_CLK)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_reload  (accept),
        .i_enable  (o_busy),
        .o_expire  (expire)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= ST_IDLE;
            rx_prev <= 1'b0;
        end else begin
            state   <= state_nx;
            rx_prev <= i_rx_valid;
        end
    end

    always_comb begin
        state_nx  = state;
        store     = 1'b0;
        err_chk_d = 1'b0;
        err_len_d = 1'b0;
        overrun_d = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && i_rx_byte == SOF) state_nx = ST_LEN;
            end
            ST_LEN: begin
                if (expire) begin
                    state_nx = ST_IDLE;
                end else if (accept) begin
                    if (i_rx_byte == 8'd0) begin
                        state_nx = ST_CHK;
                    end else if (i_rx_byte <= 8'(MAX_LEN)) begin
                        state_nx = ST_PAYLOAD;
                    end else begin
                        err_len_d = 1'b1;
                        state_nx  = ST_IDLE;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (expire) begin
                    state_nx = ST_IDLE;
                end else if (accept) begin
                    store = 1'b1;
                    if (idx_q == len_q - 5'd1) state_nx = ST_CHK;
                end
            end
            ST_CHK: begin
                if (expire) begin
                    state_nx = ST_IDLE;
                end else if (accept) begin
                    if (i_rx_byte == chk_q) begin
                        state_nx = ST_HOLD;
                    end else begin
                        err_chk_d = 1'b1;
                        state_nx  = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                // A byte here is lost even when the ack lands in the same cycle.
                overrun_d = accept;
                if (i_frame_ack) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Length, write index and running checksum for the frame being received.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            len_q <= '0;
            idx_q <= '0;
            chk_q <= '0;
        end else if (state == ST_LEN && accept) begin
            len_q <= i_rx_byte[4:0];
            idx_q <= '0;
            chk_q <= i_rx_byte;
        end else if (store) begin
            idx_q <= idx_q + 5'd1;
            chk_q <= chk_q ^ i_rx_byte;
        end
    end

    always_ff @(posedge i_clk) begin
        if (store) buf_mem[idx_q[3:0]] <= i_rx_byte;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_err_chk     <= 1'b0;
            o_err_len     <= 1'b0;
            o_err_timeout <= 1'b0;
            o_overrun     <= 1'b0;
        end else begin
            o_err_chk     <= err_chk_d;
            o_err_len     <= err_len_d;
            o_err_timeout <= expire;
            o_overrun     <= overrun_d;
        end
    end

    assign o_frame_valid = (state == ST_HOLD);
    assign o_frame_len   = o_frame_valid ? len_q : 5'd0;
    assign o_rd_data     = ({1'b0, i_rd_addr} < o_frame_len) ? buf_mem[i_rd_addr] : 8'h00;

`ifdef UART_CMD_STATS_EN
    logic [15:0] good_cnt, err_cnt;
    logic        err_any_d;

    assign err_any_d = err_chk_d | err_len_d | overrun_d | expire;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            good_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (state == ST_CHK && state_nx == ST_HOLD && good_cnt != 16'hFFFF)
                good_cnt <= good_cnt + 16'd1;
            if (err_any_d && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
        end
    end

    assign o_good_cnt = good_cnt;
    assign o_err_cnt  = err_cnt;
`else
    assign o_good_cnt = 16'd0;
    assign o_err_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - self-checking bench for uart_cmd_parser
module tb_uart_cmd_parser;

    localparam int MAX_LEN     = 16;
    localparam int TIMEOUT_CLK = 26040;

    typedef logic [7:0] bq_t [$];
    typedef struct {
        logic [7:0] b [24];
        int         n;
        int         pl_off;
        logic       exp_valid;
        int         exp_len;
        int         exp_chk;
        int         exp_lenerr;
    } vec_t;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_rx_valid = 1'b0;
    logic [7:0]  i_rx_byte = 8'h00;
    logic        i_frame_ack = 1'b0;
    logic [3:0]  i_rd_addr = 4'd0;
    logic [7:0]  o_rd_data;
    logic        o_frame_valid;
    logic [4:0]  o_frame_len;
    logic        o_busy;
    logic        o_err_chk, o_err_len, o_err_timeout, o_overrun;
    logic [15:0] o_good_cnt, o_err_cnt;

    int vectors = 0;
    int miscompares = 0;
    int cnt_chk = 0, cnt_len = 0, cnt_to = 0, cnt_ovr = 0;
    int good_model = 0;
    int err_base = 0;

    always #5 i_clk = ~i_clk;

    uart_cmd_parser #(
        .MAX_LEN     (MAX_LEN),
        .TIMEOUT_CLK (TIMEOUT_CLK)
    ) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_rx_valid    (i_rx_valid),
        .i_rx_byte     (i_rx_byte),
        .i_frame_ack   (i_frame_ack),
        .i_rd_addr     (i_rd_addr),
        .o_rd_data     (o_rd_data),
        .o_frame_valid (o_frame_valid),
        .o_frame_len   (o_frame_len),
        .o_busy        (o_busy),
        .o_err_chk     (o_err_chk),
        .o_err_len     (o_err_len),
        .o_err_timeout (o_err_timeout),
        .o_overrun     (o_overrun),
        .o_good_cnt    (o_good_cnt),
        .o_err_cnt     (o_err_cnt)
    );

    // Pulse tallies, sampled mid-cycle.
    always @(negedge i_clk) begin
        if (i_reset_n) begin
            if (o_err_chk)     cnt_chk <= cnt_chk + 1;
            if (o_err_len)     cnt_len <= cnt_len + 1;
            if (o_err_timeout) cnt_to  <= cnt_to + 1;
            if (o_overrun)     cnt_ovr <= cnt_ovr + 1;
        end
    end

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int total_err();
        return cnt_chk + cnt_len + cnt_to + cnt_ovr;
    endfunction

    function automatic int stat(input int v);
`ifdef UART_CMD_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    function automatic vec_t mk(input bq_t q, input int off, input logic v,
                                input int len, input int ec, input int el);
        vec_t r;
        for (int k = 0; k < 24; k++) r.b[k] = 8'h00;
        for (int k = 0; k < q.size(); k++) r.b[k] = q[k];
        r.n = q.size();
        r.pl_off = off;
        r.exp_valid = v;
        r.exp_len = len;
        r.exp_chk = ec;
        r.exp_lenerr = el;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        i_rx_byte = b;
        i_rx_valid = 1'b1;
        repeat (hold) step();
        i_rx_valid = 1'b0;
        step();
    endtask

    // hold <= 0 picks a random valid-level duration per byte.
    task automatic send_seq(input bq_t q, input int hold);
        for (int j = 0; j < q.size(); j++)
            send_byte(q[j], (hold > 0) ? hold : int'($urandom_range(1, 4)));
    endtask

    task automatic expect_held(input string tag, input bq_t pl);
        check({tag, "_valid"}, o_frame_valid, 1);
        check({tag, "_len"}, o_frame_len, pl.size());
        check({tag, "_busy"}, o_busy, 0);
        for (int a = 0; a < 16; a++) begin
            i_rd_addr = 4'(a);
            #1;
            check($sformatf("%s_rd%0d", tag, a), o_rd_data, (a < pl.size()) ? pl[a] : 8'h00);
        end
    endtask

    task automatic release_frame(input string tag);
        i_frame_ack = 1'b1;
        step();
        i_frame_ack = 1'b0;
        check({tag, "_ack_clr"}, o_frame_valid, 0);
        check({tag, "_ack_len"}, o_frame_len, 0);
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        step();
        step();
        i_reset_n = 1'b1;
        step();
        err_base = total_err();
        good_model = 0;
    endtask

    vec_t tbl [9];

    initial begin
        bq_t q, pl;
        int b0, b1, b2, b3, bl;

        // Reset state
        step();
        check("rst_valid", o_frame_valid, 0);
        check("rst_len", o_frame_len, 0);
        check("rst_busy", o_busy, 0);
        check("rst_errs", {o_err_chk, o_err_len, o_err_timeout, o_overrun}, 0);
        check("rst_rd", o_rd_data, 0);
        check("rst_good_cnt", o_good_cnt, 0);
        check("rst_err_cnt", o_err_cnt, 0);
        i_reset_n = 1'b1;
        step();

        // Directed table
        q = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        tbl[0] = mk(q, 2, 1, 3, 0, 0);
        q = {8'hA5, 8'h00, 8'h00};
        tbl[1] = mk(q, 2, 1, 0, 0, 0);
        q = {8'hA5, 8'h02, 8'hAA, 8'h55, 8'h00};
        tbl[2] = mk(q, 2, 0, 0, 1, 0);
        q = {8'hA5, 8'h11, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        tbl[3] = mk(q, 2, 0, 0, 0, 1);
        q = {8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F};
        tbl[4] = mk(q, 4, 1, 1, 0, 0);
        q = {8'hA5, 8'h10};
        for (int k = 0; k < 16; k++) q.push_back(8'(k * 19 + 1));
        begin
            logic [7:0] c;
            c = 8'h10;
            for (int k = 0; k < 16; k++) c = c ^ 8'(k * 19 + 1);
            q.push_back(c);
        end
        tbl[5] = mk(q, 2, 1, 16, 0, 0);
        q = {8'hA5, 8'h00, 8'h01};
        tbl[6] = mk(q, 2, 0, 0, 1, 0);
        q = {8'hA5, 8'hFF};
        tbl[7] = mk(q, 2, 0, 0, 0, 1);
        q = {8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h02};
        tbl[8] = mk(q, 2, 1, 2, 0, 0);

        for (int i = 0; i < 9; i++) begin
            b0 = cnt_chk;
            b1 = cnt_len;
            q = {};
            for (int k = 0; k < tbl[i].n; k++) q.push_back(tbl[i].b[k]);
            send_seq(q, 1 + (i % 3));
            check($sformatf("t%0d_chk_err", i), cnt_chk - b0, tbl[i].exp_chk);
            check($sformatf("t%0d_len_err", i), cnt_len - b1, tbl[i].exp_lenerr);
            if (tbl[i].exp_valid) begin
                good_model++;
                pl = {};
                for (int k = 0; k < tbl[i].exp_len; k++) pl.push_back(tbl[i].b[tbl[i].pl_off + k]);
                expect_held($sformatf("t%0d", i), pl);
                release_frame($sformatf("t%0d", i));
            end else begin
                check($sformatf("t%0d_valid", i), o_frame_valid, 0);
                check($sformatf("t%0d_busy", i), o_busy, 0);
            end
        end

        // Randomized frames against the rule model
        for (int r = 0; r < 30; r++) begin
            int len, nn;
            logic bad;
            logic [7:0] c, x;
            len = $urandom_range(0, MAX_LEN + 1);
            bad = ($urandom_range(0, 3) == 0);
            q = {};
            nn = $urandom_range(0, 2);
            for (int k = 0; k < nn; k++) begin
                x = 8'($urandom_range(0, 255));
                if (x == 8'hA5) x = 8'h00;
                q.push_back(x);
            end
            q.push_back(8'hA5);
            q.push_back(8'(len));
            pl = {};
            c = 8'(len);
            if (len <= MAX_LEN) begin
                for (int k = 0; k < len; k++) begin
                    x = 8'($urandom_range(0, 255));
                    pl.push_back(x);
                    c = c ^ x;
                end
                q = {q, pl};
                if (bad) c = c ^ (8'h01 << $urandom_range(0, 7));
                q.push_back(c);
            end
            b0 = cnt_chk;
            b1 = cnt_len;
            send_seq(q, 0);
            check($sformatf("r%0d_len_err", r), cnt_len - b1, (len > MAX_LEN) ? 1 : 0);
            check($sformatf("r%0d_chk_err", r), cnt_chk - b0, (len <= MAX_LEN && bad) ? 1 : 0);
            if (len <= MAX_LEN && !bad) begin
                good_model++;
                expect_held($sformatf("r%0d", r), pl);
                release_frame($sformatf("r%0d", r));
            end else begin
                check($sformatf("r%0d_valid", r), o_frame_valid, 0);
            end
        end
        check("stats_good", o_good_cnt, stat(good_model));
        check("stats_err", o_err_cnt, stat(total_err() - err_base));

        // Ack outside HOLD is ignored
        i_frame_ack = 1'b1;
        q = {8'hA5, 8'h01};
        send_seq(q, 1);
        i_frame_ack = 1'b0;
        q = {8'h3C, 8'h3D};
        send_seq(q, 1);
        pl = {8'h3C};
        expect_held("ack_ign", pl);
        release_frame("ack_ign");

        // Byte during HOLD with a 5-cycle valid level
        do_reset();
        q = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        send_seq(q, 1);
        b3 = cnt_ovr;
        send_byte(8'hA5, 5);
        check("ovr_pulses", cnt_ovr - b3, 1);
        pl = {8'h11, 8'h22, 8'h33};
        expect_held("ovr", pl);
        check("ovr_err_cnt", o_err_cnt, stat(1));
        check("ovr_good_cnt", o_good_cnt, stat(1));
        release_frame("ovr");
        q = {8'hA5, 8'h00, 8'h00};
        send_seq(q, 2);
        pl = {};
        expect_held("post_ovr", pl);

        // Byte in the same cycle as the ack is still dropped
        b3 = cnt_ovr;
        i_rx_byte = 8'hA5;
        i_rx_valid = 1'b1;
        i_frame_ack = 1'b1;
        step();
        i_frame_ack = 1'b0;
        step();
        i_rx_valid = 1'b0;
        step();
        check("ack_ovr_pulses", cnt_ovr - b3, 1);
        check("ack_ovr_valid", o_frame_valid, 0);
        check("ack_ovr_busy", o_busy, 0);

        // Stalled frame times out once, then parsing recovers
        b2 = cnt_to;
        q = {8'hA5, 8'h02, 8'h10};
        send_seq(q, 1);
        repeat (TIMEOUT_CLK - 10) step();
        check("to_early", cnt_to - b2, 0);
        check("to_busy", o_busy, 1);
        repeat (20) step();
        check("to_pulse", cnt_to - b2, 1);
        check("to_busy_after", o_busy, 0);
        check("to_valid", o_frame_valid, 0);
        q = {8'hA5, 8'h01, 8'h5A, 8'h5B};
        send_seq(q, 1);
        pl = {8'h5A};
        expect_held("post_to", pl);
        release_frame("post_to");

        // Reset mid-frame is a silent abort
        q = {8'hA5, 8'h03, 8'h11};
        send_seq(q, 1);
        bl = total_err();
        i_reset_n = 1'b0;
        step();
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_errs", {o_err_chk, o_err_len, o_err_timeout, o_overrun}, 0);
        check("mid_rst_err_cnt", o_err_cnt, 0);
        i_reset_n = 1'b1;
        step();
        step();
        check("mid_rst_no_pulse", total_err() - bl, 0);
        q = {8'hA5, 8'h02, 8'h0F, 8'hF0, 8'hFD};
        send_seq(q, 3);
        pl = {8'h0F, 8'hF0};
        expect_held("post_rst", pl);
        release_frame("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
